// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/trap sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN_DEF         = 64;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  localparam int unsigned CAUSE_ILLEGAL    = 2;
  localparam int unsigned CAUSE_BREAKPOINT = 3;
  localparam int unsigned CAUSE_ECALL_M    = 11;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_DRAIN = 2'd1,
    PC_TRAP  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Hazard and trap sequencer: per-stage stall/flush/bubble controls, PC redirect,
// and precise trap/mret entry after draining EX/MEM/WB.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [31:0]     id_instr_i,
  input  logic            id_load_use_i,
  input  logic            id_ecall_i,
  input  logic            id_ebreak_i,
  input  logic            id_mret_i,
  input  logic            id_ilegl_instr_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_redirect_pc_i,
  input  logic            mem_busy_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            pc_stall_o,
  output logic            if_id_stall_o,
  output logic            id_ex_stall_o,
  output logic            ex_mem_stall_o,
  output logic            if_id_flush_o,
  output logic            id_ex_bubble_o,
  output logic            pc_redirect_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            trap_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_epc_o,
  output logic [XLEN-1:0] trap_tval_o,
  output logic            mret_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  pc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            mret_q, mret_d;
  logic            id_exc;

  assign id_exc = id_valid_i &
                  (id_ilegl_instr_i | id_ecall_i | id_ebreak_i | id_mret_i);

  // State and captured trap context
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PC_RUN;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      mret_q  <= mret_d;
    end
  end

  // Next-state and combinational pipeline controls
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    mret_d         = mret_q;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pc_redirect_o  = 1'b0;
    pc_target_o    = '0;
    trap_o         = 1'b0;
    trap_cause_o   = '0;
    trap_epc_o     = '0;
    trap_tval_o    = '0;
    mret_o         = 1'b0;
    busy_o         = (state_q != PC_RUN);

    case (state_q)
      PC_RUN: begin
        if (mem_busy_i) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
        end else if (ex_redirect_i) begin
          // ID holds a wrong-path instruction, so its flags are dropped
          pc_redirect_o  = 1'b1;
          pc_target_o    = ex_redirect_pc_i;
          if_id_flush_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (id_exc) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
          state_d        = PC_DRAIN;
          cnt_d          = CNT_W'(DRAIN_CYCLES);
          epc_d          = id_pc_i;
          mret_d         = 1'b0;
          if (id_ilegl_instr_i) begin
            cause_d = XLEN'(CAUSE_ILLEGAL);
            tval_d  = XLEN'(id_instr_i);
          end else if (id_ebreak_i) begin
            cause_d = XLEN'(CAUSE_BREAKPOINT);
            tval_d  = id_pc_i;
          end else if (id_ecall_i) begin
            cause_d = XLEN'(CAUSE_ECALL_M);
            tval_d  = '0;
          end else begin
            mret_d  = 1'b1;
            cause_d = '0;
            tval_d  = '0;
          end
        end else if (id_valid_i && id_load_use_i) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end
      end

      PC_DRAIN: begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        if (!mem_busy_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = PC_TRAP;
          end
        end
      end

      PC_TRAP: begin
        pc_redirect_o = 1'b1;
        if_id_flush_o = 1'b1;
        state_d       = PC_RUN;
        if (mret_q) begin
          mret_o      = 1'b1;
          pc_target_o = csr_mepc_i;
        end else begin
          trap_o       = 1'b1;
          pc_target_o  = csr_mtvec_i;
          trap_cause_o = cause_q;
          trap_epc_o   = epc_q;
          trap_tval_o  = tval_q;
        end
      end

      default: begin
        state_d = PC_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed test-plan scenarios, then random traffic.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DRAIN = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_load_use, id_ecall, id_ebreak, id_mret, id_ilegl;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_redirect_pc;
  logic            mem_busy;
  logic [XLEN-1:0] mtvec, mepc;
  logic            pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic            if_id_flush, id_ex_bubble, pc_redirect, trap, mret, busy;
  logic [XLEN-1:0] pc_target, trap_cause, trap_epc, trap_tval;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid_i       (id_valid),
    .id_pc_i          (id_pc),
    .id_instr_i       (id_instr),
    .id_load_use_i    (id_load_use),
    .id_ecall_i       (id_ecall),
    .id_ebreak_i      (id_ebreak),
    .id_mret_i        (id_mret),
    .id_ilegl_instr_i (id_ilegl),
    .ex_redirect_i    (ex_redirect),
    .ex_redirect_pc_i (ex_redirect_pc),
    .mem_busy_i       (mem_busy),
    .csr_mtvec_i      (mtvec),
    .csr_mepc_i       (mepc),
    .pc_stall_o       (pc_stall),
    .if_id_stall_o    (if_id_stall),
    .id_ex_stall_o    (id_ex_stall),
    .ex_mem_stall_o   (ex_mem_stall),
    .if_id_flush_o    (if_id_flush),
    .id_ex_bubble_o   (id_ex_bubble),
    .pc_redirect_o    (pc_redirect),
    .pc_target_o      (pc_target),
    .trap_o           (trap),
    .trap_cause_o     (trap_cause),
    .trap_epc_o       (trap_epc),
    .trap_tval_o      (trap_tval),
    .mret_o           (mret),
    .busy_o           (busy)
  );

  // ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, flush, bubble, redirect, trap, mret, busy}
  typedef struct packed {
    logic [9:0]      ctrl;
    logic [XLEN-1:0] target;
  } exp_t;

  typedef struct packed {
    logic            is_mret;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
  } trap_rec_t;

  exp_t      exp_q[$];
  trap_rec_t trap_q[$];
  int        checks = 0;
  int        errors = 0;

  // Reference model: a pending trap counts down non-busy drain cycles, then fires once
  int        m_rem      = 0;
  bit        m_fire_now = 1'b0;
  bit        m_is_mret  = 1'b0;

  task automatic clear_flags();
    id_valid = 1'b0; id_load_use = 1'b0; id_ecall = 1'b0; id_ebreak = 1'b0;
    id_mret = 1'b0; id_ilegl = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic step();
    exp_t      e;
    trap_rec_t r;
    bit        was_fire;
    logic      s_pc, s_ifid, s_idex, s_exmem, fl, bub, red, tr, mr, bz;
    logic [XLEN-1:0] tgt;
    {s_pc, s_ifid, s_idex, s_exmem, fl, bub, red, tr, mr, bz} = '0;
    tgt = '0;
    was_fire = m_fire_now;
    if (m_fire_now) begin
      red = 1'b1; fl = 1'b1; bz = 1'b1;
      if (m_is_mret) begin mr = 1'b1; tgt = mepc; end
      else begin tr = 1'b1; tgt = mtvec; end
      m_fire_now = 1'b0;
    end else if (m_rem > 0) begin
      s_pc = 1'b1; s_ifid = 1'b1; bub = 1'b1; bz = 1'b1;
      if (!mem_busy) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_fire_now = 1'b1;
      end
    end else if (mem_busy) begin
      s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
    end else if (ex_redirect) begin
      red = 1'b1; tgt = ex_redirect_pc; fl = 1'b1; bub = 1'b1;
    end else if (id_valid && (id_ilegl || id_ecall || id_ebreak || id_mret)) begin
      s_pc = 1'b1; s_ifid = 1'b1; bub = 1'b1;
      r = '0;
      r.epc = id_pc;
      if (id_ilegl)       begin r.cause = 64'd2;  r.tval = {32'd0, id_instr}; end
      else if (id_ebreak) begin r.cause = 64'd3;  r.tval = id_pc; end
      else if (id_ecall)  begin r.cause = 64'd11; r.tval = 64'd0; end
      else                begin r.is_mret = 1'b1; r.epc = 64'd0; end
      m_is_mret = r.is_mret;
      trap_q.push_back(r);
      m_rem = DRAIN;
    end else if (id_valid && id_load_use) begin
      s_pc = 1'b1; s_ifid = 1'b1; bub = 1'b1;
    end
    if (!rst_n) begin
      m_rem = 0;
      m_fire_now = 1'b0;
      if (!was_fire) trap_q.delete();
    end
    e.ctrl   = {s_pc, s_ifid, s_idex, s_exmem, fl, bub, red, tr, mr, bz};
    e.target = tgt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t      mon_e;
  trap_rec_t mon_r;
  logic [9:0] mon_act;

  // Monitor: compares every presented cycle, and pops a trap record on each pulse
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                 id_ex_bubble, pc_redirect, trap, mret, busy};
      checks++;
      if (mon_act !== mon_e.ctrl) begin
        errors++;
        $display("FAIL ctrl t=%0t got %b expected %b", $time, mon_act, mon_e.ctrl);
      end
      checks++;
      if (pc_target !== mon_e.target) begin
        errors++;
        $display("FAIL pc_target t=%0t got %h expected %h", $time, pc_target, mon_e.target);
      end
      if (trap !== 1'b1) begin
        checks++;
        if ({trap_cause, trap_epc, trap_tval} !== '0) begin
          errors++;
          $display("FAIL trap_data_idle t=%0t got cause=%h epc=%h tval=%h expected 0",
                   $time, trap_cause, trap_epc, trap_tval);
        end
      end
      if (trap === 1'b1 || mret === 1'b1) begin
        checks++;
        if (trap_q.size() == 0) begin
          errors++;
          $display("FAIL trap_event t=%0t got trap=%b mret=%b expected no pulse", $time, trap, mret);
        end else begin
          mon_r = trap_q.pop_front();
          if ({mret, trap, trap_cause, trap_epc, trap_tval} !==
              {mon_r.is_mret, ~mon_r.is_mret, mon_r.cause, mon_r.epc, mon_r.tval}) begin
            errors++;
            $display("FAIL trap_event t=%0t got mret=%b cause=%h epc=%h tval=%h expected mret=%b cause=%h epc=%h tval=%h",
                     $time, mret, trap_cause, trap_epc, trap_tval,
                     mon_r.is_mret, mon_r.cause, mon_r.epc, mon_r.tval);
          end
        end
      end
    end
  end

  initial begin
    clear_flags();
    rst_n = 1'b0;
    id_pc = '0; id_instr = '0; ex_redirect_pc = '0; mtvec = '0; mepc = '0;
    @(posedge clk);
    #1;
    step();                                     // reset state, outputs idle
    rst_n = 1'b1;

    // load-use stall for exactly one cycle
    id_valid = 1'b1; id_load_use = 1'b1; step();
    clear_flags(); step();

    // EX redirect outranks a same-cycle ecall
    id_valid = 1'b1; id_ecall = 1'b1; ex_redirect = 1'b1;
    ex_redirect_pc = 64'h8000_0100; step();
    clear_flags(); step();

    // ecall: three drain cycles, then trap to mtvec
    id_valid = 1'b1; id_ecall = 1'b1; id_pc = 64'h8000_0040; mtvec = 64'h8000_0200;
    step();
    clear_flags(); repeat (5) step();

    // illegal instruction with two busy cycles mid-drain
    id_valid = 1'b1; id_ilegl = 1'b1; id_instr = 32'hFFFF_FFFF; id_pc = 64'h8000_0080;
    step();
    clear_flags(); step();
    mem_busy = 1'b1; step(); step();
    mem_busy = 1'b0; repeat (5) step();

    // ebreak and ilegl together: ilegl wins
    id_valid = 1'b1; id_ebreak = 1'b1; id_ilegl = 1'b1; id_instr = 32'h0000_0013;
    step();
    clear_flags(); repeat (5) step();

    // ebreak alone: tval = pc
    id_valid = 1'b1; id_ebreak = 1'b1; id_pc = 64'h8000_00C0; step();
    clear_flags(); repeat (5) step();

    // mret returns to mepc
    id_valid = 1'b1; id_mret = 1'b1; mepc = 64'h8000_0044; step();
    clear_flags(); repeat (5) step();

    // a bubble never traps or stalls
    id_ecall = 1'b1; id_load_use = 1'b1; step();
    clear_flags(); step();

    // busy in RUN defers the exception
    id_valid = 1'b1; id_ecall = 1'b1; mem_busy = 1'b1; step();
    mem_busy = 1'b0; step();
    clear_flags(); repeat (5) step();

    // reset during drain abandons the trap
    id_valid = 1'b1; id_ecall = 1'b1; step();
    clear_flags(); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; repeat (6) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_valid       = ($urandom % 10) < 7;
      id_load_use    = ($urandom % 5) == 0;
      id_ecall       = ($urandom % 25) == 0;
      id_ebreak      = ($urandom % 25) == 0;
      id_mret        = ($urandom % 25) == 0;
      id_ilegl       = ($urandom % 25) == 0;
      ex_redirect    = ($urandom % 10) == 0;
      mem_busy       = ($urandom % 6) == 0;
      rst_n          = !(($urandom % 150) == 0);
      id_pc          = {$urandom, $urandom};
      id_instr       = $urandom;
      ex_redirect_pc = {$urandom, $urandom};
      mtvec          = {$urandom, $urandom};
      mepc           = {$urandom, $urandom};
      step();
    end
    rst_n = 1'b1;
    clear_flags();
    repeat (6) step();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || trap_q.size() != 0) begin
      errors++;
      $display("FAIL drain got exp_q=%0d trap_q=%0d expected 0 0", exp_q.size(), trap_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and trap sequencer for the 5-stage RV64I pipeline (IF/ID/EX/MEM/WB).
- Consumes decode-stage hazard and exception flags and the EX-stage redirect, and produces per-stage stall, flush and bubble controls plus the PC redirect.
- Sequences precise trap entry (ecall/ebreak/illegal) and mret: drains older in-flight instructions, then signals the CSR unit and redirects fetch in a single cycle.

Parameters:
- XLEN, 64, datapath and PC width.
- DRAIN_CYCLES, 3, number of non-frozen cycles needed for the instructions in EX/MEM/WB to retire.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous reset, active-low
- id_valid_i  input  1  ID holds a real (non-bubble) instruction
- id_pc_i  input  XLEN  PC of the ID instruction
- id_instr_i  input  32  raw ID instruction word
- id_load_use_i  input  1  load-use hazard from decode
- id_ecall_i / id_ebreak_i / id_mret_i / id_ilegl_instr_i  input  1 each  decode exception flags
- ex_redirect_i  input  1  taken branch or jump resolved in EX
- ex_redirect_pc_i  input  XLEN  target of that branch or jump
- mem_busy_i  input  1  data memory not ready; freezes the pipe
- csr_mtvec_i, csr_mepc_i  input  XLEN  trap vector and return PC
- pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  output  1  hold the register
- if_id_flush_o  output  1  IF/ID loads a bubble
- id_ex_bubble_o  output  1  ID/EX loads a bubble
- pc_redirect_o  output  1  PC loads pc_target_o
- pc_target_o  output  XLEN  redirect target
- trap_o  output  1  one-cycle pulse: CSR writes mepc, mcause, mtval
- trap_cause_o, trap_epc_o, trap_tval_o  output  XLEN  trap data, valid while trap_o=1
- mret_o  output  1  one-cycle pulse: CSR restores mstatus
- busy_o  output  1  FSM is not in RUN

Behaviour:
- Reset: one clock and a synchronous active-low reset, clock port `clk`, reset port `rst_n`. With rst_n=0 at a rising edge: state=RUN, counter=0, captured pc/cause/tval=0.
- Reset mid-drain abandons the pending trap. All outputs are 0 with inputs idle.
- All outputs are combinational from state and inputs.
- States and outputs:
  - RUN: hazard resolution per the priority list below.
  - DRAIN: pc_stall, if_id_stall and id_ex_bubble asserted every cycle. Counter decrements only when mem_busy_i=0. When counter==1 and mem_busy_i=0, next state is TRAP.
  - TRAP: one cycle. pc_redirect=1 and if_id_flush=1.
    - Trap kind: trap_o=1, pc_target=csr_mtvec_i, cause/epc/tval from the captured registers.
    - Mret kind: mret_o=1, pc_target=csr_mepc_i.
    - Next state is RUN. mem_busy_i is not sampled in TRAP, because EX/MEM/WB are already empty.
- RUN priority, highest first:
  1. mem_busy_i: all four stall outputs=1. No flush, bubble or redirect. Exception capture is deferred.
  2. ex_redirect_i: pc_redirect=1, pc_target=ex_redirect_pc_i, if_id_flush=1, id_ex_bubble=1. ID flags are ignored (wrong path).
  3. id_valid_i & (ilegl|ecall|ebreak|mret):
     - Capture PC, cause and tval.
     - pc_stall=1, if_id_stall=1, id_ex_bubble=1.
     - Load counter with DRAIN_CYCLES and go to DRAIN.
  4. id_valid_i & id_load_use_i: pc_stall=1, if_id_stall=1, id_ex_bubble=1 for one cycle.
- Cause selection (priority ilegl > ebreak > ecall > mret):
  - illegal: cause=2, tval=id_instr_i zero-extended.
  - ebreak: cause=3, tval=id_pc_i.
  - ecall: cause=11, tval=0.
  - mret: mret kind, no cause.
  - epc=id_pc_i in every case.
- Latency: exception seen in RUN at cycle t gives the trap_o/mret_o pulse at cycle t+DRAIN_CYCLES+1 when no mem_busy occurs. Each busy cycle during DRAIN adds one cycle.
- The flags are sampled only when id_valid_i=1. A bubble never traps or stalls.

Decomposition:
- Shared defines file holds:
  - state encodings PC_RUN/PC_DRAIN/PC_TRAP;
  - cause constants CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11;
  - DRAIN_CYCLES default.
- Single flat module, no sub-module.

Test Plan:
- id_valid=1, id_load_use=1 for one cycle → pc_stall=if_id_stall=id_ex_bubble=1 that cycle only; busy_o stays 0.
- ex_redirect=1, target 0x8000_0100, with id_ecall=1 the same cycle → redirect to 0x8000_0100, flush+bubble, no trap, state stays RUN.
- id_ecall=1, pc 0x8000_0040, mtvec 0x8000_0200 → 3 DRAIN cycles, then trap_o=1, cause=11, epc=0x8000_0040, tval=0, pc_target=0x8000_0200, then RUN.
- id_ilegl=1, instr 0xFFFF_FFFF, with mem_busy=1 for 2 cycles mid-DRAIN → trap_o at t+6, cause=2, tval=0xFFFF_FFFF.
- id_mret=1, mepc 0x8000_0044 → mret_o=1 after drain, pc_target=0x8000_0044, trap_o=0.
- rst_n=0 during DRAIN → next cycle state RUN, all outputs 0, no trap_o or mret_o ever issued.
